// File: rtl/ysyx_22050612_pkg.sv
// Shared decode-controller definitions: state encoding, instruction
// constants and the helper that classifies multiply/divide instructions.
package ysyx_22050612_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FULL     = 2'd1,
    S_MDU_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [6:0]  OPC_OP      = 7'b0110011;
  localparam logic [6:0]  OPC_OP_32   = 7'b0111011;
  localparam logic [6:0]  F7_MULDIV   = 7'b0000001;

  // Multiply/divide/remainder: register-register op (64- or 32-bit) with the M funct7.
  function automatic logic is_mdu(input logic [31:0] inst);
    return ((inst[6:0] == OPC_OP) || (inst[6:0] == OPC_OP_32)) &&
           (inst[31:25] == F7_MULDIV);
  endfunction

endpackage

// File: rtl/ysyx_22050612_satcnt.sv
// Up-counter that sticks at all-ones instead of wrapping.
module ysyx_22050612_satcnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  // Count enabled cycles, holding once the maximum value is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_22050612_decode_ctrl.sv
// Decode-stage controller: a one-entry holding register between fetch and
// execute, with stalls for the multi-cycle MDU and a terminal ebreak halt.
module ysyx_22050612_decode_ctrl
  import ysyx_22050612_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [63:0] if_pc,
  output logic        if_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [63:0] id_pc,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        mdu_start,
  input  logic        mdu_done,
  output logic        halted,
  output logic [63:0] retired_cnt,
  output logic [31:0] stall_cnt
);

  state_t state, state_nxt;
  logic   held_mdu;
  logic   held_ebreak;
  logic   handshake;
  logic   load;

  assign held_mdu    = is_mdu(id_inst);
  assign held_ebreak = (id_inst == INST_EBREAK);

  // Next state, handshake/load strobes and the two combinational outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned and infers a latch.
    state_nxt = state;
    if_ready  = 1'b0;
    id_valid  = 1'b0;
    handshake = 1'b0;
    load      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if_ready = !flush;
        if (!flush && if_valid) begin
          load      = 1'b1;
          state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        id_valid = 1'b1;
        if (flush) begin
          state_nxt = S_IDLE;
        end else begin
          handshake = ex_ready;
          if (held_mdu || held_ebreak) begin
            // Nothing may follow these until they resolve.
            if (ex_ready) state_nxt = held_mdu ? S_MDU_WAIT : S_HALT;
          end else begin
            if_ready = ex_ready;
            if (ex_ready) begin
              if (if_valid) load = 1'b1;
              else          state_nxt = S_IDLE;
            end
          end
        end
      end
      S_MDU_WAIT: begin
        if (mdu_done) state_nxt = S_IDLE;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, holding register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      id_inst     <= INST_NOP;
      id_pc       <= '0;
      mdu_start   <= 1'b0;
      halted      <= 1'b0;
      retired_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state     <= state_nxt;
      mdu_start <= handshake && held_mdu;
      halted    <= halted || (handshake && held_ebreak);
      if (load) begin
        id_inst <= if_inst;
        id_pc   <= if_pc;
      end
      if (handshake) retired_cnt <= retired_cnt + 64'd1;
    end
  end

  ysyx_22050612_satcnt #(
    .WIDTH(32)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == S_MDU_WAIT),
    .cnt  (stall_cnt)
  );

endmodule

// File: tb/tb_ysyx_22050612_decode_ctrl.sv
// Self-checking bench for ysyx_22050612_decode_ctrl with a retire scoreboard.
module tb_ysyx_22050612_decode_ctrl;

  localparam logic [31:0] ADD    = 32'h00B5_0533;
  localparam logic [31:0] SUB    = 32'h40B5_0533;
  localparam logic [31:0] MULW   = 32'h02B5_053B;
  localparam logic [31:0] DIVU   = 32'h02B5_5533;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [63:0] id_pc;
  logic        ex_ready;
  logic        flush;
  logic        mdu_start;
  logic        mdu_done;
  logic        halted;
  logic [63:0] retired_cnt;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int mdu_pulses = 0;
  logic [95:0] sb[$];   // {inst, pc} expected at each retire, in order

  always #5 clk = ~clk;

  ysyx_22050612_decode_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_valid   (if_valid),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .if_ready   (if_ready),
    .id_valid   (id_valid),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .ex_ready   (ex_ready),
    .flush      (flush),
    .mdu_start  (mdu_start),
    .mdu_done   (mdu_done),
    .halted     (halted),
    .retired_cnt(retired_cnt),
    .stall_cnt  (stall_cnt)
  );

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in IDLE with execute stalled; ends in FULL.
  task automatic load(input logic [31:0] inst, input logic [63:0] pc, input bit retire);
    if_valid = 1'b1; if_inst = inst; if_pc = pc; ex_ready = 1'b0;
    if (retire) sb.push_back({inst, pc});
    tick();
    if_valid = 1'b0;
  endtask

  // Retire monitor: compare every observed handshake against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && mdu_start) mdu_pulses++;
    if (rst_n && id_valid && ex_ready && !flush) begin
      if (sb.size() == 0) check("sb_unexpected_retire", {id_inst, id_pc}, '0);
      else                check("sb_retire", {id_inst, id_pc}, sb.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0;
    ex_ready = 1'b0; flush = 1'b0; mdu_done = 1'b0;
    #12;
    check("rst_id_inst", id_inst, NOP);
    check("rst_id_pc", id_pc, 0);
    check("rst_retired", retired_cnt, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_halted", halted, 0);
    check("rst_mdu_start", mdu_start, 0);
    check("rst_id_valid", id_valid, 0);
    check("rst_if_ready", if_ready, 1);
    tick();
    rst_n = 1'b1;

    // Pass-through stream: add, sub (not MDU despite opcode), add.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ins;
      ins = (i == 1) ? SUB : ADD;
      ex_ready = 1'b1;
      if_valid = (i < 3);
      if_inst  = ins;
      if_pc    = 64'h8000_0000 + 64'(4 * i);
      if (i < 3) sb.push_back({ins, if_pc});
      #1;
      check("pt_id_valid", id_valid, i != 0);
      check("pt_if_ready", if_ready, 1);
      tick();
    end
    check("pt_retired", retired_cnt, 3);
    check("pt_idle", id_valid, 0);

    // Execute stalled for four cycles: held instruction must not move.
    load(ADD, 64'h100, 1'b1);
    if_valid = 1'b1; if_inst = SUB; if_pc = 64'h200;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_if_ready", if_ready, 0);
      check("stall_id", {id_inst, id_pc}, {ADD, 64'h100});
      check("stall_retired", retired_cnt, 3);
      tick();
    end
    if_valid = 1'b0; ex_ready = 1'b1;
    tick();
    check("stall_retired_after", retired_cnt, 4);

    // Flush in FULL beats a ready handshake.
    load(ADD, 64'h300, 1'b0);
    flush = 1'b1; if_valid = 1'b1; if_inst = SUB; if_pc = 64'h304; ex_ready = 1'b1;
    #1;
    check("flush_if_ready", if_ready, 0);
    tick();
    flush = 1'b0; if_valid = 1'b0;
    #1;
    check("flush_idle", id_valid, 0);
    check("flush_retired", retired_cnt, 4);

    // mulw: one start pulse, five wait cycles, flush/if_valid ignored meanwhile.
    load(MULW, 64'h400, 1'b1);
    if_valid = 1'b1; if_inst = ADD; if_pc = 64'h404; ex_ready = 1'b1;
    #1;
    check("mdu_if_ready_full", if_ready, 0);
    tick();
    check("mdu_start_hi", mdu_start, 1);
    check("mdu_retired", retired_cnt, 5);
    flush = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      mdu_done = (c == 5);
      #1;
      check("mdu_wait_if_ready", if_ready, 0);
      check("mdu_wait_id_valid", id_valid, 0);
      tick();
      if (c == 1) check("mdu_start_lo", mdu_start, 0);
    end
    mdu_done = 1'b0; flush = 1'b0; if_valid = 1'b0;
    check("mdu_stall_cnt", stall_cnt, 5);
    #1;
    check("mdu_back_idle", if_ready, 1);
    mdu_done = 1'b1;   // stray done in IDLE
    tick();
    mdu_done = 1'b0;
    check("done_ignored_stall", stall_cnt, 5);
    check("done_ignored_idle", id_valid, 0);

    // Reset asserted in the middle of a divu wait.
    load(DIVU, 64'h500, 1'b1);
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    tick(); tick();
    check("divu_stall_cnt", stall_cnt, 7);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mdu_start", mdu_start, 0);
    check("rst_mid_stall", stall_cnt, 0);
    check("rst_mid_retired", retired_cnt, 0);
    check("rst_mid_if_ready", if_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_mid_no_start", mdu_start, 0);

    // ebreak halts until reset.
    load(EBREAK, 64'h600, 1'b1);
    if_valid = 1'b1; if_inst = ADD; if_pc = 64'h604; ex_ready = 1'b1;
    #1;
    check("ebreak_if_ready", if_ready, 0);
    tick();
    check("halted", halted, 1);
    for (int i = 0; i < 10; i++) begin
      flush = i[0];
      #1;
      check("halt_io", {if_ready, id_valid, halted, mdu_start}, 4'b0010);
      check("halt_retired", retired_cnt, 1);
      tick();
    end
    flush = 1'b0;
    rst_n = 1'b0;
    #1;
    check("halt_rst_halted", halted, 0);
    check("halt_rst_inst", id_inst, NOP);
    tick();
    rst_n = 1'b1; if_valid = 1'b0;
    tick();

    check("sb_drained", sb.size(), 0);
    check("mdu_pulse_count", mdu_pulses, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
